game_step_datapath: RTL and testbench

//  Datapath/responder for the game-state control FSM. Consumes its control strobes
//  (counter enable/clear, obstacle load, row position, check, score increment) and the

---
 rtl/game_step_datapath_if.sv | 29 ++
 rtl/game_step_datapath.sv | 155 +++++++++++++++
 tb/tb_game_step_datapath.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_step_datapath_if.sv
// Control/status bundle between the game-state control FSM (master) and its
// step datapath (slave).
interface game_step_datapath_if;
  logic       counter_clear;
  logic       counter_en;
  logic       ld_new_obstacle;
  logic [7:0] position;
  logic       check_game_state;
  logic       score_inc;
  logic [2:0] lane_map;
  logic       change_state;
  logic [1:0] game_state;
  logic [9:0] score;
  logic [2:0] obstacle_lane;
  logic [2:0] obstacle_row;
  logic       hit;

  modport master (
    output counter_clear, counter_en, ld_new_obstacle, position, check_game_state,
           score_inc, lane_map,
    input  change_state, game_state, score, obstacle_lane, obstacle_row, hit
  );

  modport slave (
    input  counter_clear, counter_en, ld_new_obstacle, position, check_game_state,
           score_inc, lane_map,
    output change_state, game_state, score, obstacle_lane, obstacle_row, hit
  );
endinterface

// File: rtl/game_step_datapath.sv
// Step timer, obstacle generator, collision detector and score keeper answering the
// game-state control FSM. All outputs are registered.
module game_step_datapath #(
  parameter int unsigned TICKS_PER_STEP = 12_500_000,
  parameter int unsigned CNT_W          = 24,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5
) (
  input logic                 clk_i,
  input logic                 restart_i,
  game_step_datapath_if.slave ctrl_io
);

  localparam logic [1:0]       GsRun     = 2'b01;
  localparam logic [1:0]       GsCrashed = 2'b00;
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TICKS_PER_STEP - 1);
  localparam logic [9:0]       ScoreMax  = 10'd1023;

  typedef enum logic [0:0] {StCount, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             change_state_q, change_state_d;

  logic [7:0] lfsr_q, lfsr_d;
  logic       ld_prev_q;
  logic       ld_rise;
  logic [2:0] lane_q, lane_d;
  logic [2:0] row_q, row_d;
  logic [1:0] game_state_q, game_state_d;
  logic [9:0] score_q, score_d;
  logic       hit_q, hit_d;

  logic       pos_onehot;
  logic [2:0] pos_idx;
  logic       crash;
  logic       running;

  // Step counter FSM: state register
  always_ff @(posedge clk_i) begin
    if (restart_i) begin
      state_q        <= StCount;
      cnt_q          <= '0;
      change_state_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      change_state_q <= change_state_d;
    end
  end

  // Step counter FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ctrl_io.counter_clear) begin
      state_d = StCount;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StCount: begin
          if (ctrl_io.counter_en) begin
            if (cnt_q == CntLast) begin
              cnt_d   = '0;
              state_d = StDone;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        StDone: begin
          if (!ctrl_io.counter_en) state_d = StCount;
        end
        default: state_d = StCount;
      endcase
    end
  end

  // Step counter FSM: output, registered so changeState lands on the transition edge
  always_comb begin
    change_state_d = (state_d == StDone);
  end

  // Obstacle, collision and score datapath
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    ld_rise = ctrl_io.ld_new_obstacle & ~ld_prev_q;

    lane_d = lane_q;
    if (ld_rise) begin
      unique case (lfsr_q[1:0])
        2'b00:   lane_d = 3'b100;
        2'b01:   lane_d = 3'b010;
        2'b10:   lane_d = 3'b001;
        default: lane_d = 3'b100;
      endcase
    end

    // x & (x-1) clears the lowest set bit; zero result means at most one bit set
    pos_onehot = (ctrl_io.position != 8'd0) &&
                 ((ctrl_io.position & (ctrl_io.position - 8'd1)) == 8'd0);
    pos_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (ctrl_io.position[i]) pos_idx = 3'(i);
    end
    row_d = pos_onehot ? pos_idx : row_q;

    running = (game_state_q == GsRun);
    crash   = ctrl_io.check_game_state & running & (|(lane_q & ctrl_io.lane_map));

    game_state_d = game_state_q;
    hit_d        = 1'b0;
    score_d      = score_q;
    if (ctrl_io.counter_clear) begin
      game_state_d = GsRun;
      score_d      = 10'd0;
    end else begin
      if (crash) begin
        game_state_d = GsCrashed;
        hit_d        = 1'b1;
      end
      // Uses pre-edge game state, so a crash and a score in the same cycle both land
      if (ctrl_io.score_inc && running && (score_q != ScoreMax)) begin
        score_d = score_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (restart_i) begin
      lfsr_q       <= LFSR_SEED;
      ld_prev_q    <= 1'b0;
      lane_q       <= 3'b010;
      row_q        <= 3'd0;
      game_state_q <= GsRun;
      score_q      <= 10'd0;
      hit_q        <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      ld_prev_q    <= ctrl_io.ld_new_obstacle;
      lane_q       <= lane_d;
      row_q        <= row_d;
      game_state_q <= game_state_d;
      score_q      <= score_d;
      hit_q        <= hit_d;
    end
  end

  assign ctrl_io.change_state  = change_state_q;
  assign ctrl_io.game_state    = game_state_q;
  assign ctrl_io.score         = score_q;
  assign ctrl_io.obstacle_lane = lane_q;
  assign ctrl_io.obstacle_row  = row_q;
  assign ctrl_io.hit           = hit_q;

endmodule

// File: tb/tb_game_step_datapath.sv
// Bench for game_step_datapath: directed scenarios plus a randomized run checked against
// a cycle-level behavioural model of the game rules.
module tb_game_step_datapath;

  localparam int Ticks = 4;

  logic clk = 1'b0;
  logic restart = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  game_step_datapath_if bus ();

  game_step_datapath #(
    .TICKS_PER_STEP(Ticks),
    .CNT_W         (24),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .clk_i    (clk),
    .restart_i(restart),
    .ctrl_io  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: state after the next edge, computed from the game rules
  int         m_enabled;
  bit         m_change;
  logic [1:0] m_game;
  int         m_score;
  logic [2:0] m_lane;
  logic [2:0] m_row;
  bit         m_hit;
  logic [7:0] m_lfsr;
  bit         m_ldprev;

  task automatic model_step(input bit rst);
    bit crash, scores;
    if (rst) begin
      m_enabled = 0; m_change = 0; m_game = 2'b01; m_score = 0;
      m_lane = 3'b010; m_row = 3'd0; m_hit = 0; m_lfsr = 8'hA5; m_ldprev = 0;
    end else begin
      crash  = bus.check_game_state && (m_game == 2'b01) && ((m_lane & bus.lane_map) != 3'b000);
      scores = bus.score_inc && (m_game == 2'b01) && (m_score < 1023);
      if (bus.counter_clear) begin
        m_enabled = 0; m_change = 0;
      end else if (m_change) begin
        if (!bus.counter_en) m_change = 0;
      end else if (bus.counter_en) begin
        m_enabled++;
        if (m_enabled == Ticks) begin
          m_change = 1; m_enabled = 0;
        end
      end
      if (bus.ld_new_obstacle && !m_ldprev) begin
        case (m_lfsr[1:0])
          2'd0: m_lane = 3'b100;
          2'd1: m_lane = 3'b010;
          2'd2: m_lane = 3'b001;
          default: m_lane = 3'b100;
        endcase
      end
      m_ldprev = bus.ld_new_obstacle;
      if ($countones(bus.position) == 1) begin
        for (int i = 0; i < 8; i++) if (bus.position[i]) m_row = 3'(i);
      end
      m_hit = crash && !bus.counter_clear;
      if (bus.counter_clear) m_game = 2'b01;
      else if (crash) m_game = 2'b00;
      if (bus.counter_clear) m_score = 0;
      else if (scores) m_score++;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  task automatic cycle(input bit rst = 0);
    restart = rst;
    model_step(rst);
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.counter_clear = 0; bus.counter_en = 0; bus.ld_new_obstacle = 0;
    bus.position = 8'd0; bus.check_game_state = 0; bus.score_inc = 0; bus.lane_map = 3'b000;
  endtask

  task automatic clear_cycle();
    idle_inputs();
    bus.counter_clear = 1;
    cycle();
    bus.counter_clear = 0;
  endtask

  // Pulses ldNewObstacle until the model predicts the wanted lane
  task automatic load_lane(input logic [2:0] want);
    bit ok = 0;
    for (int k = 0; k < 64 && !ok; k++) begin
      if (m_lane == want) ok = 1;
      else begin
        bus.ld_new_obstacle = 1; cycle();
        bus.ld_new_obstacle = 0; cycle();
      end
    end
    total_cnt++;
    if (!ok || bus.obstacle_lane !== want)
      $display("FAIL load_lane: lane=%b required=%b (reached=%0d)", bus.obstacle_lane, want, ok);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    idle_inputs();
    cycle(1);
    total_cnt++;
    if (bus.game_state !== 2'b01) $display("FAIL reset_game: got %b want 01", bus.game_state);
    else pass_cnt++;
    total_cnt++;
    if (bus.score !== 10'd0) $display("FAIL reset_score: got %0d want 0", bus.score);
    else pass_cnt++;
    total_cnt++;
    if (bus.change_state !== 1'b0) $display("FAIL reset_change: got %b want 0", bus.change_state);
    else pass_cnt++;
    total_cnt++;
    if (bus.obstacle_lane !== 3'b010) $display("FAIL reset_lane: got %b want 010", bus.obstacle_lane);
    else pass_cnt++;
    total_cnt++;
    if (bus.hit !== 1'b0 || bus.obstacle_row !== 3'd0)
      $display("FAIL reset_hit_row: hit=%b row=%0d want 0/0", bus.hit, bus.obstacle_row);
    else pass_cnt++;
  endtask

  task automatic test_change_state();
    bit exp_seq[6] = '{0, 0, 0, 1, 1, 0};
    bit en_seq[6]  = '{1, 1, 1, 1, 1, 0};
    clear_cycle();
    for (int i = 0; i < 6; i++) begin
      bus.counter_en = en_seq[i];
      cycle();
      total_cnt++;
      if (bus.change_state !== exp_seq[i])
        $display("FAIL change_state edge %0d: got %b want %b", i + 1, bus.change_state, exp_seq[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_enable_hold();
    bit en_seq[5]  = '{1, 0, 1, 1, 1};
    bit exp_seq[5] = '{0, 0, 0, 0, 1};
    clear_cycle();
    for (int i = 0; i < 5; i++) begin
      bus.counter_en = en_seq[i];
      cycle();
      total_cnt++;
      if (bus.change_state !== exp_seq[i])
        $display("FAIL enable_hold edge %0d: got %b want %b", i + 1, bus.change_state, exp_seq[i]);
      else pass_cnt++;
    end
    bus.counter_en = 0;
    cycle();
  endtask

  task automatic test_collision();
    logic [1:0] exp_game[3] = '{2'b00, 2'b00, 2'b00};
    bit         exp_hit[3]  = '{1, 0, 0};
    clear_cycle();
    load_lane(3'b100);
    bus.lane_map = 3'b100;
    bus.check_game_state = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total_cnt++;
      if (bus.game_state !== exp_game[i] || bus.hit !== exp_hit[i])
        $display("FAIL collision edge %0d: game=%b hit=%b want %b/%b", i + 1, bus.game_state,
                 bus.hit, exp_game[i], exp_hit[i]);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  task automatic test_miss_and_same_cycle();
    clear_cycle();
    load_lane(3'b001);
    bus.lane_map = 3'b010; bus.check_game_state = 1; bus.score_inc = 1;
    cycle();
    total_cnt++;
    if (bus.game_state !== 2'b01 || bus.score !== 10'd1)
      $display("FAIL miss: game=%b score=%0d want 01/1", bus.game_state, bus.score);
    else pass_cnt++;
    bus.lane_map = 3'b000;
    cycle();
    total_cnt++;
    if (bus.game_state !== 2'b01 || bus.hit !== 1'b0 || bus.score !== 10'd2)
      $display("FAIL no_player: game=%b hit=%b score=%0d want 01/0/2", bus.game_state, bus.hit,
               bus.score);
    else pass_cnt++;
    bus.lane_map = 3'b011;
    cycle();
    total_cnt++;
    if (bus.game_state !== 2'b00 || bus.hit !== 1'b1 || bus.score !== 10'd3)
      $display("FAIL crash_and_score: game=%b hit=%b score=%0d want 00/1/3", bus.game_state,
               bus.hit, bus.score);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (bus.score !== 10'd3 || bus.hit !== 1'b0)
      $display("FAIL crashed_hold: score=%0d hit=%b want 3/0", bus.score, bus.hit);
    else pass_cnt++;
    idle_inputs();
  endtask

  task automatic test_row();
    logic [7:0] pos_seq[4] = '{8'b0010_0000, 8'b0000_0000, 8'b0100_0001, 8'b1000_0000};
    logic [2:0] exp_seq[4] = '{3'd5, 3'd5, 3'd5, 3'd7};
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      bus.position = pos_seq[i];
      cycle();
      total_cnt++;
      if (bus.obstacle_row !== exp_seq[i])
        $display("FAIL row %b: got %0d want %0d", pos_seq[i], bus.obstacle_row, exp_seq[i]);
      else pass_cnt++;
    end
    bus.position = 8'd0;
  endtask

  task automatic test_saturation();
    clear_cycle();
    bus.score_inc = 1;
    repeat (1023) cycle();
    total_cnt++;
    if (bus.score !== 10'd1023) $display("FAIL score_1023: got %0d want 1023", bus.score);
    else pass_cnt++;
    cycle();
    total_cnt++;
    if (bus.score !== 10'd1023) $display("FAIL score_sat: got %0d want 1023", bus.score);
    else pass_cnt++;
    bus.score_inc = 0;
    bus.counter_clear = 1;
    cycle();
    bus.counter_clear = 0;
    total_cnt++;
    if (bus.score !== 10'd0 || bus.game_state !== 2'b01)
      $display("FAIL sat_clear: score=%0d game=%b want 0/01", bus.score, bus.game_state);
    else pass_cnt++;
  endtask

  task automatic test_clear_with_load();
    idle_inputs();
    cycle();
    bus.counter_clear = 1; bus.ld_new_obstacle = 1;
    cycle();
    idle_inputs();
    total_cnt++;
    if (bus.obstacle_lane !== m_lane || bus.change_state !== 1'b0 || bus.score !== 10'd0)
      $display("FAIL clear_with_load: lane=%b change=%b score=%0d want %b/0/0", bus.obstacle_lane,
               bus.change_state, bus.score, m_lane);
    else pass_cnt++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.counter_clear    = ($urandom_range(0, 15) == 0);
      bus.counter_en       = ($urandom_range(0, 3) != 0);
      bus.ld_new_obstacle  = 1'($urandom_range(0, 1));
      bus.check_game_state = 1'($urandom_range(0, 1));
      bus.score_inc        = 1'($urandom_range(0, 1));
      bus.lane_map         = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 2))
        0:       bus.position = 8'd1 << $urandom_range(0, 7);
        1:       bus.position = 8'd0;
        default: bus.position = 8'($urandom);
      endcase
      cycle($urandom_range(0, 63) == 0);
      total_cnt++;
      if (bus.change_state !== m_change || bus.game_state !== m_game ||
          bus.score !== 10'(m_score) || bus.obstacle_lane !== m_lane ||
          bus.obstacle_row !== m_row || bus.hit !== m_hit)
        $display("FAIL random cycle %0d: chg/gs/sc/lane/row/hit=%b/%b/%0d/%b/%0d/%b want %b/%b/%0d/%b/%0d/%b",
                 n, bus.change_state, bus.game_state, bus.score, bus.obstacle_lane,
                 bus.obstacle_row, bus.hit, m_change, m_game, m_score, m_lane, m_row, m_hit);
      else pass_cnt++;
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_change_state();
    test_enable_hold();
    test_collision();
    test_miss_and_same_cycle();
    test_row();
    test_saturation();
    test_clear_with_load();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
